// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller sequencing a binary event counter through start/pause/stop/terminal count
module counter_sequencer #(
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] DEFAULT_TC = WIDTH'(7)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_tc,
  input  logic             cfg_periodic,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] tc_reg, tc_n, cnt_n;
  logic per_reg, per_n, pulse_n, err_n, active;
  assign active = (state == RUN) || (state == HOLD);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tc_n    = tc_reg;
    per_n   = per_reg;
    pulse_n = 1'b0;
    err_n   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      if (cfg_we && active) err_n = 1'b1;
      if (cfg_we && !active) begin
        tc_n  = cfg_tc;
        per_n = cfg_periodic;
      end
      if (start && !active) begin
        state_n = RUN;
        cnt_n   = '0;
      end else if (active && pause) begin
        state_n = HOLD;
      end else if (active) begin
        // leaving HOLD counts on the same edge, so a pause costs exactly its length
        pulse_n = (cnt == tc_reg);
        state_n = (cnt == tc_reg && !per_reg) ? DONE : RUN;
        cnt_n   = (cnt != tc_reg) ? cnt + 1'b1 : (per_reg ? '0 : cnt);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tc_reg   <= DEFAULT_TC;
      per_reg  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tc_pulse <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tc_reg   <= tc_n;
      per_reg  <= per_n;
      busy     <= (state_n == RUN) || (state_n == HOLD);
      done     <= (state_n == DONE);
      tc_pulse <= pulse_n;
      cfg_err  <= err_n;
    end
  end
endmodule
